// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiply sequencer for the EX stage: captures operands on a MUL,
// runs one add/shift step per cycle while stalling the pipeline, then pulses done_o.
module mul_seq_ctrl #(
    parameter int         DATA_W   = 32,
    parameter logic [3:0] MUL_CODE = 4'b1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              start;
    logic [DATA_W-1:0] acc_step;

    assign start    = ex_valid_i && (alu_ctrl_i == MUL_CODE) && !flush_i;
    // Accumulator value after this cycle's iteration; also the product on the last one.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        stall_o  = 1'b0;
        done_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = src1_i;
                    mplier_d = src2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    stall_o  = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                stall_o  = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    result_d = acc_step;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // The MUL is still in EX here; DONE never restarts, so no re-trigger.
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An aborted multiply must neither stall nor publish a partial result.
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
            stall_o  = 1'b0;
        end
        // Keep stall low while reset is held even if a MUL sits in EX.
        if (rst_i) begin
            stall_o = 1'b0;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed and random cycles against a timeline model that
// tracks cycles since issue and the expected product.
module tb_mul_seq_ctrl;

    localparam int         W   = 32;
    localparam logic [3:0] MUL = 4'b1000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ex_valid_i = 1'b0;
    logic [3:0]    alu_ctrl_i = 4'b0000;
    logic [W-1:0]  src1_i = '0;
    logic [W-1:0]  src2_i = '0;
    logic          flush_i = 1'b0;
    logic          stall_o, busy_o, done_o;
    logic [W-1:0]  result_o;

    int checks = 0;
    int failures = 0;

    // Model: phase = cycles since issue (-1 = nothing in flight), issue cycle is phase 0,
    // stall over phases 0..W, done at phase W+1, result visible from phase W+1 on.
    int           phase = -1;
    logic [W-1:0] pending = '0;
    logic [W-1:0] ref_result = '0;

    mul_seq_ctrl #(.DATA_W(W), .MUL_CODE(MUL)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ex_valid_i (ex_valid_i),
        .alu_ctrl_i (alu_ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic f);
        int           eff;
        logic         st;
        logic         exp_stall, exp_busy, exp_done;
        logic [63:0]  full;
        @(posedge clk_i);
        #1;
        ex_valid_i = v; alu_ctrl_i = c; src1_i = a; src2_i = b; flush_i = f;
        st  = v && (c == MUL) && !f;
        eff = (phase < 0) ? (st ? 0 : -1) : phase;
        if (phase < 0 && eff == 0) begin
            full    = a * b;
            pending = full[W-1:0];
        end
        exp_stall = !f && (eff >= 0) && (eff <= W);
        exp_busy  = (phase >= 1);
        exp_done  = (phase == W + 1);
        @(negedge clk_i);
        check("stall", {31'b0, stall_o}, {31'b0, exp_stall});
        check("busy",  {31'b0, busy_o},  {31'b0, exp_busy});
        check("done",  {31'b0, done_o},  {31'b0, exp_done});
        check("result", result_o, ref_result);
        if (f || eff < 0 || eff == W + 1) begin
            phase = -1;
        end else begin
            if (eff == W) ref_result = pending;
            phase = eff + 1;
        end
        $display("cyc v=%0b op=%b a=%h b=%h fl=%0b -> stall=%0b busy=%0b done=%0b res=%h",
                 v, c, a, b, f, stall_o, busy_o, done_o, result_o);
    endtask

    // Holds a MUL in EX through its stall and DONE cycles, as the pipeline would.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int stalls, output int done_at, output int dones);
        stalls = 0; done_at = -1; dones = 0;
        for (int k = 0; k < W + 2; k++) begin
            cycle(1'b1, MUL, a, b, 1'b0);
            if (stall_o) stalls++;
            if (done_o) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 4'b0000, '0, '0, 1'b0);
    endtask

    initial begin
        int           stalls, done_at, dones, done_at2, dones2;
        logic [W-1:0] held;
        logic [3:0]   codes [3];
        codes[0] = 4'b0000; codes[1] = 4'b0010; codes[2] = 4'b1010;

        // Reset values
        #2;
        check("rst_stall",  {31'b0, stall_o}, 32'd0);
        check("rst_busy",   {31'b0, busy_o},  32'd0);
        check("rst_done",   {31'b0, done_o},  32'd0);
        check("rst_result", result_o, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        bubble(2);

        // Non-MUL ALU codes and MUL without a valid slot never stall
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                cycle(1'b1, codes[i], $urandom, $urandom, 1'b0);
                check("alu_nostall", {31'b0, stall_o}, 32'd0);
                check("alu_nobusy",  {31'b0, busy_o},  32'd0);
            end
        end
        cycle(1'b0, MUL, 32'd7, 32'd6, 1'b0);
        check("invalid_mul_nostall", {31'b0, stall_o}, 32'd0);
        bubble(1);
        check("invalid_mul_nobusy", {31'b0, busy_o}, 32'd0);

        // 7*6: 33 stall cycles, done in cycle 33
        run_mul(32'd7, 32'd6, stalls, done_at, dones);
        check("mul7x6_stalls", 32'(stalls), 32'd33);
        check("mul7x6_done_at", 32'(done_at), 32'd33);
        check("mul7x6_dones", 32'(dones), 32'd1);
        check("mul7x6_result", result_o, 32'h0000_002A);
        bubble(3);
        check("mul7x6_held", result_o, 32'h0000_002A);

        // Boundary products
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, done_at, dones);
        check("mul_ffxff", result_o, 32'h0000_0001);
        run_mul(32'h0001_0000, 32'h0001_0000, stalls, done_at, dones);
        check("mul_2p16sq", result_o, 32'h0000_0000);
        run_mul(32'hFFFF_FFFD, 32'd5, stalls, done_at, dones);
        check("mul_neg3x5", result_o, 32'hFFFF_FFF1);

        // Back-to-back: second MUL in the cycle after done
        run_mul(32'd3, 32'd4, stalls, done_at, dones);
        check("b2b_first", result_o, 32'h0000_000C);
        run_mul(32'd5, 32'd5, stalls, done_at2, dones2);
        check("b2b_gap", 32'(W + 2 + done_at2 - done_at), 32'd34);
        check("b2b_dones", 32'(dones + dones2), 32'd2);
        check("b2b_second", result_o, 32'h0000_0019);
        bubble(2);

        // Flush in run cycle 10
        held = result_o;
        for (int k = 0; k < 10; k++) cycle(1'b1, MUL, 32'h1234, 32'h10, 1'b0);
        cycle(1'b1, MUL, 32'h1234, 32'h10, 1'b1);
        check("flush_stall_drop", {31'b0, stall_o}, 32'd0);
        cycle(1'b0, 4'b0000, '0, '0, 1'b0);
        check("flush_busy_next", {31'b0, busy_o}, 32'd0);
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(1'b0, 4'b0000, '0, '0, 1'b0);
            if (done_o) dones++;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_result_kept", result_o, held);
        run_mul(32'd2, 32'd3, stalls, done_at, dones);
        check("after_flush_2x3", result_o, 32'h0000_0006);

        // Asynchronous reset mid-run
        for (int k = 0; k < 5; k++) cycle(1'b1, MUL, 32'hAB, 32'hCD, 1'b0);
        @(posedge clk_i);
        #2;
        check("pre_rst_busy", {31'b0, busy_o}, 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check("arst_stall",  {31'b0, stall_o}, 32'd0);
        check("arst_busy",   {31'b0, busy_o},  32'd0);
        check("arst_done",   {31'b0, done_o},  32'd0);
        check("arst_result", result_o, 32'd0);
        phase = -1; ref_result = '0;
        @(posedge clk_i);
        #1 rst_i = 1'b0; ex_valid_i = 1'b0; alu_ctrl_i = 4'b0000;
        run_mul(32'd9, 32'd9, stalls, done_at, dones);
        check("post_rst_stalls", 32'(stalls), 32'd33);
        check("post_rst_9x9", result_o, 32'h0000_0051);

        // Random traffic, including flushes at arbitrary points
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? MUL : 4'($urandom_range(0, 15)),
                  $urandom, $urandom, $urandom_range(0, 39) == 0);
        end
        bubble(W + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer for a multi-cycle iterative shift-add multiply in the EX stage of the pipelined CPU.
- Detects a MUL operation: ALU control code 4'b1000 while the EX slot holds a valid instruction.
- Captures the operands, runs one add/shift iteration per cycle, and stalls the pipeline until the product is ready.
- Presents the low DATA_W bits of the product for one cycle so EX/MEM can capture it. All other ALU codes pass through with no stall.

Parameters:
- DATA_W, 32, operand and result width.
- MUL_CODE, 4'b1000, ALU control code that triggers a multiply.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- ex_valid_i  input  1  EX stage holds a valid (non-bubble) instruction.
- alu_ctrl_i  input  4  ALU control code of the EX instruction.
- src1_i  input  DATA_W  multiplicand (rs value after forwarding).
- src2_i  input  DATA_W  multiplier (rt value after forwarding).
- flush_i  input  1  EX flush (branch taken); aborts any multiply.
- stall_o  output  1  freeze PC, IF/ID, ID/EX; insert no EX/MEM update.
- busy_o  output  1  sequencer not in IDLE.
- done_o  output  1  result_o valid this cycle (one-cycle pulse).
- result_o  output  DATA_W  low DATA_W bits of src1*src2.

Behaviour:
- One clock domain. rst_i is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - stall_o=0, busy_o=0, done_o=0.
  - result_o=0.
  - Internal mcand, mplier, acc and cnt all 0.
- States: IDLE, RUN, DONE.
- start = ex_valid_i && alu_ctrl_i==MUL_CODE && !flush_i.
- IDLE:
  - On start: load mcand=src1_i, mplier=src2_i, acc=0, cnt=0; next state RUN.
  - Otherwise remain in IDLE.
- RUN (one iteration per cycle):
  - If mplier[0], acc <= acc + mcand (mod 2^DATA_W).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - When cnt==DATA_W-1 (the final iteration), next state DONE and result_o <= the final acc value.
- DONE: done_o=1; next state IDLE unconditionally.
- No early termination; latency is fixed.
- stall_o is combinational:
  - stall_o = !flush_i && ((state==IDLE && start) || state==RUN).
  - stall_o is 0 in DONE, so the pipeline advances exactly once with result_o valid.
- Latency with issue in cycle 0:
  - stall_o high for cycles 0..DATA_W (33 cycles at default).
  - done_o high in cycle DATA_W+1.
- Arithmetic: signed and unsigned products share the same low DATA_W bits, so there is no sign handling. Upper product bits are discarded.
- busy_o = state!=IDLE.
- result_o holds its last value until the next DONE. It changes only on entry to DONE or on reset.
- The MUL instruction is still in EX during DONE, but DONE never starts a new multiply, so it is not re-triggered. A second MUL arriving the cycle after DONE starts normally from IDLE (back-to-back supported).
- flush_i in any state:
  - Next state IDLE; stall_o=0 that cycle.
  - done_o is not asserted for the aborted operation; result_o is unchanged.
  - flush_i in DONE still lets done_o=1 appear that cycle; the consumer discards it via its own flush.
- rst_i mid-operation: immediate return to reset values; no done_o pulse.
- Operands are sampled only at start. Changes on src1_i/src2_i during RUN are ignored.
- ex_valid_i=0 with alu_ctrl_i==MUL_CODE: no start, no stall.

Test Plan:
- ADD (alu_ctrl_i=0000), SUB (0010), SLT (1010) with ex_valid_i=1 -> stall_o=0, busy_o=0, done_o never asserted.
- MUL 7*6 issued at cycle 0 -> stall_o=1 for exactly 33 cycles, done_o=1 only in cycle 33, result_o=0x0000002A held afterwards.
- Boundary products:
  - 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001.
  - 0x00010000*0x00010000 -> result_o=0x00000000.
  - 0xFFFFFFFD*5 -> result_o=0xFFFFFFF1.
- Back-to-back: MUL 3*4, then MUL 5*5 presented in the cycle after done_o -> two done_o pulses 34 cycles apart with results 0x0C then 0x19. No extra pulse from the first MUL lingering in DONE.
- flush_i pulsed in RUN cycle 10 of 0x1234*0x10:
  - stall_o drops in that cycle and busy_o=0 the next cycle.
  - No done_o; result_o keeps its previous value.
  - A following MUL 2*3 yields 0x6.
- rst_i asserted asynchronously mid-cycle during RUN cycle 5 -> all outputs 0 immediately without waiting for a clock edge. After release, MUL 9*9 yields 0x51 with the full 33-cycle stall.
